cpu_bus_decoder: RTL
====================

# cpu_bus_decoder

Single-master bus decoder sitting between the CPU core and the peripheral slaves in the module address map (ram, version string, io, uart, and later entries). It accepts one CPU access at a time, matches the address against each entry's inclusive start/end range, strobes the selected slave, and waits for its ready. It then returns registered read data with an ack, or an error for unmapped addresses and timeouts.

## Interface
- ADDR_W, address_width (16): CPU and slave address width.
- DATA_W, data_width (32): data width.
- NUM_SLAVES, num_entries: number of mapped slaves; slave index = module_bus enumeration value.
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before error (used only with BUS_TIMEOUT_EN).
- clk_i  in  1  system clock; single clock domain.
- reset_n_i  in  1  asynchronous active-low reset.
- cpu_addr_i  in  ADDR_W  access address, sampled with the request.
- cpu_wdata_i  in  DATA_W  write data, sampled with the request.
- cpu_we_i  in  1  write request; one-cycle pulse.
- cpu_re_i  in  1  read request; one-cycle pulse.
- cpu_rdata_o  out  DATA_W  read data, valid while cpu_ack_o is high.
- cpu_ack_o  out  1  one-cycle successful-completion pulse.
- cpu_err_o  out  1  one-cycle error-completion pulse.
- slv_sel_o  out  NUM_SLAVES  one-hot slave select, held from ACCESS through WAIT.
- slv_addr_o  out  ADDR_W  latched address, held for the whole transaction.
- slv_wdata_o  out  DATA_W  latched write data.
- slv_we_o / slv_re_o  out  1  one-cycle strobes in ACCESS.
- slv_rdata_i  in  data_reg_inputs_t  per-slave read data.
- slv_ready_i  in  NUM_SLAVES  per-slave completion.
- err_addr_o  out  ADDR_W  address of the most recent errored access; sticky.

## Operation
- FSM states: IDLE, DECODE, ACCESS, WAIT, RESP. Reset state is IDLE.
- IDLE: on cpu_we_i or cpu_re_i, latch address, wdata and direction, then go to DECODE. If both are high, the access is a write.
- Requests outside IDLE are ignored. The CPU must not issue a new request before it sees ack or err.
- DECODE: slave i matches when start(i) <= addr <= end(i), inclusive, unsigned. If several slaves match, the lowest index wins.
  - Match: latch the slave index, go to ACCESS.
  - No match: set the error flag, capture err_addr_o, go to RESP.
- ACCESS: drive slv_sel_o and one strobe (we or re) for exactly one cycle.
  - If slv_ready_i[idx] is high in this cycle, capture slv_rdata_i[idx] and go to RESP.
  - Otherwise go to WAIT.
- WAIT: hold sel. When slv_ready_i[idx] is high, capture read data and go to RESP. Ready bits of unselected slaves are ignored.
- RESP: pulse cpu_ack_o or cpu_err_o for one cycle, then return to IDLE.
  - cpu_rdata_o is the captured data on a read ack.
  - cpu_rdata_o is 0 on a write ack and on every error.
- All outputs are registered. Reset values: every output 0, including err_addr_o.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. Strobes and sel drop asynchronously, and no ack or err is produced.

## Timing
- Cycle 0 is the request. DECODE is cycle 1, ACCESS cycle 2, and ack is high in cycle 3 when the slave is ready in ACCESS.
- Each extra WAIT cycle adds one cycle of latency.
- An unmapped address gives err in cycle 2.
- Throughput: the earliest next request is the cycle after ack or err.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit-minimum counter, sized by $clog2(TIMEOUT_CYCLES+1), clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES with no ready, capture err_addr_o, go to RESP with err, and drop sel.
  - If ready and timeout occur in the same cycle, ready wins.
- BUS_TIMEOUT_EN undefined: WAIT holds indefinitely and no counter is synthesised.

## Structure
- Add to the shared CPU register package:
  - bus_state_t enum (IDLE, DECODE, ACCESS, WAIT, RESP).
  - BUS_TIMEOUT_CYCLES constant (255).
- Continue to use get_address_start/get_address_end and data_reg_inputs_t from the same package.
- Sub-module cpu_bus_addr_match: combinational; takes the address and produces a one-hot match vector plus a hit flag over all entries. The FSM and the output registers stay in cpu_bus_decoder.

## Test plan
- Read 0x9004, io ready in ACCESS with data 0x12345678 -> ack in cycle 3, cpu_rdata_o = 0x12345678, slv_sel_o = 1<<io_e for cycles 2–3 only.
- Write 0x9100 with 0xA5, uart ready after 4 WAIT cycles -> slv_we_o one pulse, slv_wdata_o = 0xA5, ack in cycle 7, rdata 0.
- Boundaries: 0x80FC selects version_string; 0x8100 and 0xA000 each give err in cycle 2, err_addr_o = 0x8100 / 0xA000, no strobes.
- BUS_TIMEOUT_EN, slave never ready -> err exactly TIMEOUT_CYCLES cycles after WAIT entry. Then repeat with ready arriving in the final cycle -> ack, not err.
- Request while busy, plus both we/re in one request -> extra request ignored, and the dual request is performed as a write.
- reset_n_i low for 1 cycle during WAIT -> all outputs 0 at once, no ack, IDLE accepts a new read at 0x0004 afterwards.

Source files
------------

// File: rtl/cpu_bus_decoder_pkg.sv
// Shared CPU register package: module address map, slave enumeration and bus
// decoder types used by cpu_bus_decoder and its address matcher.
package cpu_bus_decoder_pkg;

  localparam int ADDR_WIDTH         = 16;
  localparam int DATA_WIDTH         = 32;
  localparam int NUM_ENTRIES        = 4;
  localparam int BUS_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ram_e,
    version_string_e,
    io_e,
    uart_e
  } module_bus_t;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACCESS,
    WAIT,
    RESP
  } bus_state_t;

  typedef logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] data_reg_inputs_t;

  function automatic logic [ADDR_WIDTH-1:0] get_address_start(input module_bus_t m);
    case (m)
      ram_e:            return 16'h0000;
      version_string_e: return 16'h8000;
      io_e:             return 16'h9000;
      uart_e:           return 16'h9100;
      default:          return '1;
    endcase
  endfunction

  // Unknown entries get start > end so they can never match.
  function automatic logic [ADDR_WIDTH-1:0] get_address_end(input module_bus_t m);
    case (m)
      ram_e:            return 16'h7FFF;
      version_string_e: return 16'h80FF;
      io_e:             return 16'h90FF;
      uart_e:           return 16'h91FF;
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_addr_match.sv
// Combinational address matcher: one-hot match over all address-map entries,
// lowest index wins when ranges overlap.
module cpu_bus_addr_match
  import cpu_bus_decoder_pkg::*;
#(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int NUM_SLAVES = NUM_ENTRIES
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] match_o,
  output logic                  hit_o
);

  always_comb begin
    match_o = '0;
    hit_o   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o &&
          addr_i >= get_address_start(module_bus_t'(i)) &&
          addr_i <= get_address_end(module_bus_t'(i))) begin
        match_o[i] = 1'b1;
        hit_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_decoder.sv
// Single-master CPU bus decoder: IDLE/DECODE/ACCESS/WAIT/RESP handshake to the
// mapped slaves. Define BUS_TIMEOUT_EN to enable the WAIT-state timeout.
module cpu_bus_decoder
  import cpu_bus_decoder_pkg::*;
#(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int NUM_SLAVES = NUM_ENTRIES
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_re_i,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  output logic                  cpu_ack_o,
  output logic                  cpu_err_o,
  output logic [NUM_SLAVES-1:0] slv_sel_o,
  output logic [ADDR_W-1:0]     slv_addr_o,
  output logic [DATA_W-1:0]     slv_wdata_o,
  output logic                  slv_we_o,
  output logic                  slv_re_o,
  input  data_reg_inputs_t      slv_rdata_i,
  input  logic [NUM_SLAVES-1:0] slv_ready_i,
  output logic [ADDR_W-1:0]     err_addr_o
);

  bus_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d, re_q, re_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] match;
  logic                  hit;
  logic                  tgt_ready;
  logic [DATA_W-1:0]     tgt_rdata;

  cpu_bus_addr_match #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_match (
    .addr_i  (addr_q),
    .match_o (match),
    .hit_o   (hit)
  );

  // sel_q doubles as the latched slave index for ready and read-data selection.
  assign tgt_ready = |(slv_ready_i & sel_q);

  always_comb begin
    tgt_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) tgt_rdata = slv_rdata_i[i];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    sel_d      = sel_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    err_addr_d = err_addr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_we_i || cpu_re_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          write_d = cpu_we_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (hit) begin
          sel_d   = match;
          we_d    = write_q;
          re_d    = !write_q;
          state_d = ACCESS;
        end else begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = RESP;
        end
      end
      ACCESS, WAIT: begin
        if (tgt_ready) begin
          ack_d   = 1'b1;
          rdata_d = write_q ? '0 : tgt_rdata;
          state_d = RESP;
        end else if (state_q == ACCESS) begin
          state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          sel_d      = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      re_q       <= re_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign cpu_ack_o   = ack_q;
  assign cpu_err_o   = err_q;
  assign slv_sel_o   = sel_q;
  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_we_o    = we_q;
  assign slv_re_o    = re_q;
  assign err_addr_o  = err_addr_q;

endmodule
